pool_map_collector: RTL and testbench
=====================================

Name: pool_map_collector

Overview:
- Downstream stage of the conv→ReLU→pool pipeline. Consumes the pooled pixel stream (dout/valid_out).
- Applies output stride decimation: the pooling window slides with stride 1, so stride 2 gives standard 2x2-step pooling.
- Stores the kept samples in an internal frame buffer. Once the frame is complete, drains them in raster order over a valid/ready stream.
- Signals frame completion, config errors and dropped input.

Parameters:
- DATA_W, 8: pixel width (signed).
- MAX_W, 64: max pool-output map width supported.
- MAX_H, 64: max pool-output map height supported.
- ADDR_W, 12: buffer address width; buffer depth 2**ADDR_W ≥ MAX_W*MAX_H.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches map_width/map_height/stride and arms collection.
- map_width  in  8  pool windows per row (undecimated).
- map_height  in  8  pool window rows (undecimated).
- stride  in  2  decimation step; legal values 1 or 2.
- valid_in  in  1  pooled sample valid.
- din  in  DATA_W  signed pooled sample.
- out_data  out  DATA_W  signed drained sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  high with the final drained sample.
- out_count  out  16  number of samples stored for the current frame.
- busy  out  1  high in COLLECT or DRAIN.
- frame_done  out  1  one-cycle pulse after the last sample is accepted.
- cfg_err  out  1  one-cycle pulse on an illegal start.
- drop_err  out  1  sticky; cleared only by the next accepted start or by reset.

Behaviour:
- Reset (asynchronous, immediate): FSM goes to IDLE; all counters are cleared; outputs out_data, out_valid, out_last, out_count, busy, frame_done, cfg_err and drop_err all go to 0. Buffer contents are don't-care. Reset mid-frame abandons the frame with no frame_done.
- FSM states are IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - start with legal config → COLLECT. Legal config: 1 ≤ map_width ≤ MAX_W, 1 ≤ map_height ≤ MAX_H, stride ∈ {1,2}.
  - On entering COLLECT: clear col/row/write pointers and drop_err; set out_count = ceil(W/s)*ceil(H/s).
  - start with illegal config: cfg_err pulses the next cycle; FSM stays in IDLE.
  - valid_in while in IDLE sets drop_err; the sample is discarded.
- COLLECT:
  - Each valid_in advances col; at col==W-1, col wraps to 0 and row increments.
  - A sample is written to buffer[wr_ptr++] iff (col mod s)==0 and (row mod s)==0.
  - A valid_in at row==H-1, col==W-1 is processed as normal; the next state is DRAIN.
  - start in COLLECT is ignored.
- DRAIN:
  - Synchronous-read buffer with a registered output stage. out_valid rises no later than 2 cycles after DRAIN entry.
  - out_data/out_valid/out_last hold stable while out_valid && !out_ready.
  - With out_ready held high, one sample transfers per cycle with no bubbles after the first.
  - out_last is asserted only with element out_count-1.
  - The handshake where out_last transfers → DONE.
  - valid_in in DRAIN sets drop_err and is discarded. start is ignored.
- DONE: frame_done pulses for exactly one cycle; out_valid = 0; next state IDLE. out_count holds its value until the next start.
- busy = (state==COLLECT || state==DRAIN).
- Arithmetic rules: col/row counters are 8-bit; decimation uses the LSB of col/row when s=2. wr_ptr and rd_ptr are ADDR_W bits and never wrap within a legal frame. Data is passed through unmodified; no saturation.
- Simultaneous events:
  - valid_in arriving in the same cycle as the start that leaves IDLE is treated as an IDLE drop and sets drop_err. drop_err is cleared on the cycle after that start.
  - rst dominates all other inputs.

Test Plan:
- 4x4 map, stride 2, din = 1..16 with valid_in every cycle, out_ready=1 → out_count=4; outputs 1,3,9,11; out_last with 11; frame_done one cycle after.
- 5x5 map, stride 2, din = 1..25 with random valid_in gaps → outputs 1,3,5,11,13,15,21,23,25; out_count=9.
- 3x3 map, stride 1, din = -4..4; out_ready toggling 1,0,0,1 pseudo-randomly → all 9 values in order, no loss or duplication; data held stable while stalled.
- Illegal starts: map_width=0, then stride=3, then map_height=65 → cfg_err pulses each time; busy stays 0.
- valid_in while IDLE → drop_err=1, no output. Next legal start clears drop_err; a 2x2 stride-1 frame of 7,8,9,10 then drains normally.
- Assert rst midway through COLLECT of a 4x4 frame → all outputs 0 immediately, no frame_done. A fresh 2x2 stride-2 frame afterwards outputs a single sample (the first din) with out_last=1.

Source files
------------

// File: rtl/pool_map_collector.sv
// pool_map_collector
// ------------------
// Last stage of the conv -> ReLU -> pool pipeline. It takes the pooled sample
// stream, keeps every stride-th window in both directions, stores the kept
// samples in a frame buffer, and then drains them in raster order over a
// valid/ready stream.
//
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   start           : one-cycle pulse that latches map_width/map_height/stride
//   map_width       : pool windows per row before decimation
//   map_height      : pool window rows before decimation
//   stride          : decimation step, 1 or 2
//   valid_in, din   : pooled sample stream (signed)
//   out_data        : drained sample (signed)
//   out_valid       : out_data valid
//   out_ready       : consumer accepts out_data
//   out_last        : marks the final drained sample of the frame
//   out_count       : number of samples stored for the current frame
//   busy            : high while collecting or draining
//   frame_done      : one-cycle pulse after the last sample is accepted
//   cfg_err         : one-cycle pulse after a start with an illegal config
//   drop_err        : sticky; a sample arrived while not collecting
module pool_map_collector #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 64,
    parameter int MAX_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               map_width,
    input  logic [7:0]               map_height,
    input  logic [1:0]               stride,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [15:0]              out_count,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     cfg_err,
    output logic                     drop_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [8:0] MAX_W_L = 9'(MAX_W);
    localparam logic [8:0] MAX_H_L = 9'(MAX_H);

    state_t                     state_r;
    logic [7:0]                 width_r;
    logic [7:0]                 height_r;
    logic                       stride_two_r;
    logic [7:0]                 col_r;
    logic [7:0]                 row_r;
    logic [ADDR_W-1:0]          wr_ptr_r;
    // Read issue counter is wider than the address so a full 2**ADDR_W frame
    // can still be told apart from an empty one.
    logic [15:0]                rd_cnt_r;
    logic                       s1_valid_r;
    logic                       s1_last_r;
    logic signed [DATA_W-1:0]   s1_data_r;
    logic signed [DATA_W-1:0]   out_data_r;
    logic                       out_valid_r;
    logic                       out_last_r;
    logic [15:0]                out_count_r;
    logic                       busy_r;
    logic                       frame_done_r;
    logic                       cfg_err_r;
    logic                       drop_err_r;

    logic signed [DATA_W-1:0]   mem_r [0:(2**ADDR_W)-1];

    logic                       cfg_ok_s;
    logic [7:0]                 w_cells_s;
    logic [7:0]                 h_cells_s;
    logic [15:0]                count_s;
    logic                       keep_s;
    logic                       row_end_s;
    logic                       last_in_s;
    logic                       wr_en_s;
    logic                       advance_s;
    logic                       s1_en_s;
    logic                       rd_more_s;
    logic                       rd_en_s;
    logic                       last_xfer_s;

    // Config check and stored-sample count for the frame being started.
    always_comb begin
        cfg_ok_s  = (map_width != 8'd0) && ({1'b0, map_width} <= MAX_W_L) &&
                    (map_height != 8'd0) && ({1'b0, map_height} <= MAX_H_L) &&
                    ((stride == 2'd1) || (stride == 2'd2));
        w_cells_s = map_width;
        h_cells_s = map_height;
        if (stride == 2'd2) begin
            // ceil(x/2) computed in 9 bits so x=255 cannot overflow
            w_cells_s = 8'(({1'b0, map_width} + 9'd1) >> 1);
            h_cells_s = 8'(({1'b0, map_height} + 9'd1) >> 1);
        end else begin
            w_cells_s = map_width;
            h_cells_s = map_height;
        end
        count_s = {8'd0, w_cells_s} * {8'd0, h_cells_s};
    end

    // Collection decode: decimation keep test, row/frame end, buffer write.
    always_comb begin
        keep_s    = (!stride_two_r) || ((col_r[0] == 1'b0) && (row_r[0] == 1'b0));
        row_end_s = (col_r == (width_r - 8'd1));
        last_in_s = row_end_s && (row_r == (height_r - 8'd1));
        wr_en_s   = (state_r == ST_COLLECT) && valid_in && keep_s;
    end

    // Drain pipeline control: buffer read stage feeds the output register.
    // The read stage may only refill when it is empty or moving forward.
    always_comb begin
        advance_s   = (!out_valid_r) || out_ready;
        s1_en_s     = (state_r == ST_DRAIN) && ((!s1_valid_r) || advance_s);
        rd_more_s   = (rd_cnt_r < out_count_r);
        rd_en_s     = s1_en_s && rd_more_s;
        last_xfer_s = (state_r == ST_DRAIN) && out_valid_r && out_ready && out_last_r;
    end

    // Frame buffer: write port during collection, enabled synchronous read
    // during drain. Contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
        if (rd_en_s) begin
            s1_data_r <= mem_r[rd_cnt_r[ADDR_W-1:0]];
        end
    end

    // Control FSM with all registered status and stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            width_r      <= 8'd0;
            height_r     <= 8'd0;
            stride_two_r <= 1'b0;
            col_r        <= 8'd0;
            row_r        <= 8'd0;
            wr_ptr_r     <= '0;
            rd_cnt_r     <= 16'd0;
            s1_valid_r   <= 1'b0;
            s1_last_r    <= 1'b0;
            out_data_r   <= '0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_count_r  <= 16'd0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            cfg_err_r    <= 1'b0;
            drop_err_r   <= 1'b0;
        end else begin
            cfg_err_r    <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (valid_in) begin
                        drop_err_r <= 1'b1;
                    end
                    if (start) begin
                        if (cfg_ok_s) begin
                            // the clear overrides a same-cycle IDLE drop
                            width_r      <= map_width;
                            height_r     <= map_height;
                            stride_two_r <= (stride == 2'd2);
                            col_r        <= 8'd0;
                            row_r        <= 8'd0;
                            wr_ptr_r     <= '0;
                            rd_cnt_r     <= 16'd0;
                            s1_valid_r   <= 1'b0;
                            s1_last_r    <= 1'b0;
                            out_count_r  <= count_s;
                            drop_err_r   <= 1'b0;
                            busy_r       <= 1'b1;
                            state_r      <= ST_COLLECT;
                        end else begin
                            cfg_err_r <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (valid_in) begin
                        if (keep_s) begin
                            wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                        if (row_end_s) begin
                            col_r <= 8'd0;
                            row_r <= row_r + 8'd1;
                        end else begin
                            col_r <= col_r + 8'd1;
                        end
                        if (last_in_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (valid_in) begin
                        drop_err_r <= 1'b1;
                    end
                    if (s1_en_s) begin
                        s1_valid_r <= rd_more_s;
                        s1_last_r  <= rd_more_s && (rd_cnt_r == (out_count_r - 16'd1));
                        if (rd_more_s) begin
                            rd_cnt_r <= rd_cnt_r + 16'd1;
                        end
                    end
                    if (last_xfer_s) begin
                        out_valid_r  <= 1'b0;
                        out_last_r   <= 1'b0;
                        frame_done_r <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= ST_DONE;
                    end else if (advance_s) begin
                        out_valid_r <= s1_valid_r;
                        out_last_r  <= s1_last_r;
                        out_data_r  <= s1_data_r;
                    end
                end
                ST_DONE: begin
                    if (valid_in) begin
                        drop_err_r <= 1'b1;
                    end
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign out_count  = out_count_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign cfg_err    = cfg_err_r;
    assign drop_err   = drop_err_r;

endmodule

// File: tb/tb_pool_map_collector.sv
// Testbench for pool_map_collector: directed frames checked against a raster
// model of the decimated map, plus literal expected output lists.
module tb_pool_map_collector;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        map_width;
    logic [7:0]        map_height;
    logic [1:0]        stride;
    logic              valid_in;
    logic signed [7:0] din;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [15:0]       out_count;
    logic              busy;
    logic              frame_done;
    logic              cfg_err;
    logic              drop_err;

    int tests;
    int fails;
    int exp_q[$];
    int got_q[$];
    int lit_q[$];
    bit done_seen;
    bit done_due;
    bit prev_stall;
    int prev_data;
    int prev_last;
    bit ready_mode;

    pool_map_collector #(
        .DATA_W(8), .MAX_W(64), .MAX_H(64), .ADDR_W(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .map_width(map_width),
        .map_height(map_height), .stride(stride), .valid_in(valid_in),
        .din(din), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_count(out_count),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
        .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // out_ready driver: always 1, or pseudo-random while ready_mode is set
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Per-cycle compare against the model queue, sampled on the falling edge
    always @(negedge clk) begin
        int e;
        if (rst) begin
            prev_stall = 1'b0;
            done_due   = 1'b0;
        end else begin
            check("frame_done_timing", frame_done, done_due);
            if (frame_done) done_seen = 1'b1;
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            done_due = 1'b0;
            if (out_valid && out_ready) begin
                check("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                    check("out_last", out_last, exp_q.size() == 0);
                    done_due = (exp_q.size() == 0);
                end
                got_q.push_back(out_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic compare_log(input string name);
        check({name, "_len"}, got_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < got_q.size(); i++) begin
            check({name, "_val"}, got_q[i], lit_q[i]);
        end
    endtask

    task automatic pulse_start(input int w, input int h, input int s);
        @(posedge clk);
        #1;
        start      = 1'b1;
        map_width  = 8'(w);
        map_height = 8'(h);
        stride     = 2'(s);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input int s,
                             input int first, input bit gaps, input int lit_cnt);
        int cnt;
        int n;
        got_q.delete();
        exp_q.delete();
        done_seen = 1'b0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                if ((r % s == 0) && (c % s == 0)) exp_q.push_back(first + r * w + c);
        cnt = exp_q.size();
        check("model_count", cnt, lit_cnt);
        pulse_start(w, h, s);
        check("busy_after_start", busy, 1);
        check("out_count", out_count, cnt);
        check("drop_err_cleared", drop_err, 0);
        for (int i = 0; i < w * h; i++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
            end
            valid_in = 1'b1;
            din      = 8'(first + i);
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
        for (int k = 0; k < 400; k++) begin
            if (done_seen) break;
            @(posedge clk);
        end
        check("frame_done_seen", done_seen, 1);
        check("model_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("busy_after_frame", busy, 0);
        check("out_count_hold", out_count, cnt);
        check("no_drop", drop_err, 0);
    endtask

    task automatic bad_start(input int w, input int h, input int s);
        pulse_start(w, h, s);
        check("cfg_err_pulse", cfg_err, 1);
        check("busy_bad_start", busy, 0);
        @(posedge clk);
        #1;
        check("cfg_err_clear", cfg_err, 0);
        check("busy_still_idle", busy, 0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        ready_mode = 1'b0;
        done_seen  = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        map_width  = 8'd0;
        map_height = 8'd0;
        stride     = 2'd0;
        valid_in   = 1'b0;
        din        = 8'sd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_count", out_count, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_drop_err", drop_err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 4x4, stride 2, back-to-back input
        run_frame(4, 4, 2, 1, 1'b0, 4);
        lit_q = {1, 3, 9, 11};
        compare_log("t1_4x4_s2");

        // 5x5, stride 2, random input gaps
        run_frame(5, 5, 2, 1, 1'b1, 9);
        lit_q = {1, 3, 5, 11, 13, 15, 21, 23, 25};
        compare_log("t2_5x5_s2");

        // 3x3, stride 1, negative data, random backpressure
        ready_mode = 1'b1;
        run_frame(3, 3, 1, -4, 1'b0, 9);
        ready_mode = 1'b0;
        lit_q = {-4, -3, -2, -1, 0, 1, 2, 3, 4};
        compare_log("t3_3x3_s1");

        // illegal configurations
        bad_start(0, 4, 1);
        bad_start(4, 4, 3);
        bad_start(4, 65, 1);

        // sample while idle is dropped and flagged
        valid_in = 1'b1;
        din      = 8'sd55;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("idle_drop_err", drop_err, 1);
        check("idle_no_output", out_valid, 0);
        @(posedge clk);
        #1;
        check("drop_err_sticky", drop_err, 1);
        run_frame(2, 2, 1, 7, 1'b0, 4);
        lit_q = {7, 8, 9, 10};
        compare_log("t5_2x2_s1");

        // reset in the middle of collection
        got_q.delete();
        exp_q.delete();
        pulse_start(4, 4, 2);
        check("busy_before_rst", busy, 1);
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1;
            din      = 8'(40 + i);
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        rst      = 1'b1;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_out_count", out_count, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_drop_err", drop_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("after_rst_no_output", got_q.size(), 0);
        run_frame(2, 2, 2, 21, 1'b0, 1);
        lit_q = {21};
        compare_log("t6_2x2_s2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
